// File: rtl/mc_pkg.sv
// Shared definitions for the multi-cycle RV32 subset control path:
// FSM state type, opcode/funct3 constants and the encodings driven
// onto the datapath select lines and the trap cause output.
package mc_pkg;

   typedef enum logic [3:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC_R,
      S_EXEC_I,
      S_MEM_ADDR,
      S_MEM_RD,
      S_MEM_WR,
      S_WB_ALU,
      S_WB_MEM,
      S_BRANCH,
      S_TRAP
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_WORD = 3'b010;
   localparam logic [2:0] F3_BEQ  = 3'b000;

   localparam logic [1:0] ALU_OP_ADD   = 2'b00;
   localparam logic [1:0] ALU_OP_SUB   = 2'b01;
   localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

   localparam logic [1:0] SRC_B_RS2  = 2'b00;
   localparam logic [1:0] SRC_B_FOUR = 2'b01;
   localparam logic [1:0] SRC_B_IMM  = 2'b10;

   localparam logic [1:0] TRAP_NONE    = 2'b00;
   localparam logic [1:0] TRAP_ILLEGAL = 2'b01;
   localparam logic [1:0] TRAP_TIMEOUT = 2'b10;

endpackage

// File: rtl/mc_opcode_decode.sv
// Combinational instruction classifier for the multi-cycle controller.
// Ports:
//   opcode  in  7  IR[6:0]
//   funct3  in  3  IR[14:12]
//   is_r    out 1  R-type ALU
//   is_i    out 1  I-type ALU
//   is_ld   out 1  LW
//   is_st   out 1  SW
//   is_br   out 1  BEQ
//   legal   out 1  one of the above
module mc_opcode_decode
   import mc_pkg::*;
(
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   output logic       is_r,
   output logic       is_i,
   output logic       is_ld,
   output logic       is_st,
   output logic       is_br,
   output logic       legal
);

   always_comb begin
      is_r  = (opcode == OP_R);
      is_i  = (opcode == OP_IMM);
      is_ld = (opcode == OP_LOAD)   && (funct3 == F3_WORD);
      is_st = (opcode == OP_STORE)  && (funct3 == F3_WORD);
      is_br = (opcode == OP_BRANCH) && (funct3 == F3_BEQ);
      legal = is_r | is_i | is_ld | is_st | is_br;
   end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle control FSM for the RV32 subset core (R-type, I-ALU, LW, SW,
// BEQ). One memory port is shared between fetch and data access through a
// req/ready handshake; an illegal instruction or a memory wait longer than
// MEM_TIMEOUT cycles parks the FSM in a sticky trap state.
// Ports:
//   clk, rst (async, active high)
//   opcode, funct3, zero, mem_ready       inputs from IR / ALU / memory
//   mem_req, mem_we, addr_sel             memory port control
//   ir_we, pc_we, pc_src                  IR/old_pc latch and PC update
//   alu_src_a, alu_src_b, alu_op          ALU operand/op selects
//   reg_we, wb_sel                        register file write-back
//   retire                                final-cycle pulse
//   trap, trap_cause                      sticky halt indicator and cause
module multicycle_ctrl
   import mc_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 255,
   parameter int unsigned CNT_W       = 8
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] opcode,
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic       pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [1:0] alu_op,
   output logic       reg_we,
   output logic       wb_sel,
   output logic       retire,
   output logic       trap,
   output logic [1:0] trap_cause
);

   localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

   state_t           state;
   state_t           state_nx;
   logic [CNT_W-1:0] wait_cnt;
   logic             timeout_hit;
   logic             is_r, is_i, is_ld, is_st, is_br, legal;

   mc_opcode_decode u_dec (
      .opcode (opcode),
      .funct3 (funct3),
      .is_r   (is_r),
      .is_i   (is_i),
      .is_ld  (is_ld),
      .is_st  (is_st),
      .is_br  (is_br),
      .legal  (legal)
   );

   // Only consulted from the memory states; a same-cycle mem_ready wins.
   assign timeout_hit = (MEM_TIMEOUT != 0) && (wait_cnt == TIMEOUT_CNT) && !mem_ready;

   always_comb begin
      state_nx = state;
      case (state)
         S_FETCH:    if (mem_ready) state_nx = S_DECODE;
                     else if (timeout_hit) state_nx = S_TRAP;
         S_DECODE:   if (!legal) state_nx = S_TRAP;
                     else if (is_r) state_nx = S_EXEC_R;
                     else if (is_i) state_nx = S_EXEC_I;
                     else if (is_ld || is_st) state_nx = S_MEM_ADDR;
                     else state_nx = S_BRANCH;
         S_EXEC_R:   state_nx = S_WB_ALU;
         S_EXEC_I:   state_nx = S_WB_ALU;
         S_MEM_ADDR: state_nx = is_st ? S_MEM_WR : S_MEM_RD;
         S_MEM_RD:   if (mem_ready) state_nx = S_WB_MEM;
                     else if (timeout_hit) state_nx = S_TRAP;
         S_MEM_WR:   if (mem_ready) state_nx = S_FETCH;
                     else if (timeout_hit) state_nx = S_TRAP;
         S_WB_ALU:   state_nx = S_FETCH;
         S_WB_MEM:   state_nx = S_FETCH;
         S_BRANCH:   state_nx = S_FETCH;
         S_TRAP:     state_nx = S_TRAP;
         default:    state_nx = S_TRAP;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= S_FETCH;
         wait_cnt   <= '0;
         trap       <= 1'b0;
         trap_cause <= TRAP_NONE;
      end else begin
         state <= state_nx;
         // Every state change clears the counter, which covers entry into
         // FETCH, MEM_RD and MEM_WR; it saturates rather than wrapping.
         if (state_nx != state)
            wait_cnt <= '0;
         else if (!mem_ready && (wait_cnt != '1))
            wait_cnt <= wait_cnt + 1'b1;
         if ((state != S_TRAP) && (state_nx == S_TRAP)) begin
            trap       <= 1'b1;
            trap_cause <= (state == S_DECODE) ? TRAP_ILLEGAL : TRAP_TIMEOUT;
         end
      end
   end

   // Controls are decoded from state; holding rst forces them all low so a
   // reset during an access drops mem_req immediately.
   always_comb begin
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      addr_sel  = 1'b0;
      ir_we     = 1'b0;
      pc_we     = 1'b0;
      pc_src    = 1'b0;
      alu_src_a = 1'b0;
      alu_src_b = SRC_B_RS2;
      alu_op    = ALU_OP_ADD;
      reg_we    = 1'b0;
      wb_sel    = 1'b0;
      retire    = 1'b0;
      if (!rst) begin
         case (state)
            S_FETCH: begin
               mem_req   = 1'b1;
               alu_src_b = SRC_B_FOUR;
               ir_we     = mem_ready;
               pc_we     = mem_ready;
            end
            S_DECODE: begin
               alu_src_a = 1'b1;
               alu_src_b = SRC_B_IMM;
            end
            S_EXEC_R: begin
               alu_src_b = SRC_B_RS2;
               alu_op    = ALU_OP_FUNCT;
            end
            S_EXEC_I: begin
               alu_src_b = SRC_B_IMM;
               alu_op    = ALU_OP_FUNCT;
            end
            S_MEM_ADDR: alu_src_b = SRC_B_IMM;
            S_MEM_RD: begin
               mem_req  = 1'b1;
               addr_sel = 1'b1;
            end
            S_MEM_WR: begin
               mem_req  = 1'b1;
               mem_we   = 1'b1;
               addr_sel = 1'b1;
               retire   = mem_ready;
            end
            S_WB_ALU: begin
               reg_we = 1'b1;
               retire = 1'b1;
            end
            S_WB_MEM: begin
               reg_we = 1'b1;
               wb_sel = 1'b1;
               retire = 1'b1;
            end
            S_BRANCH: begin
               alu_op    = ALU_OP_SUB;
               alu_src_b = SRC_B_RS2;
               pc_src    = 1'b1;
               pc_we     = zero;
               retire    = 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl: directed scenarios followed by a
// stream of random instructions with random memory wait states. Expected
// control words per cycle come from an instruction-level model of the
// control sequence.
module tb_multicycle_ctrl;

   localparam int unsigned TO = 4;

   typedef struct packed {
      logic       mem_req;
      logic       mem_we;
      logic       addr_sel;
      logic       ir_we;
      logic       pc_we;
      logic       pc_src;
      logic       alu_src_a;
      logic [1:0] alu_src_b;
      logic [1:0] alu_op;
      logic       reg_we;
      logic       wb_sel;
      logic       retire;
      logic       trap;
      logic [1:0] trap_cause;
   } ctl_t;

   typedef enum {K_R, K_I, K_LW, K_SW, K_BR, K_ILL} kind_e;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_a;
   logic [1:0] alu_src_b, alu_op;
   logic       reg_we, wb_sel, retire, trap;
   logic [1:0] trap_cause;
   ctl_t       obs;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 clk = ~clk;

   multicycle_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .opcode     (opcode),
      .funct3     (funct3),
      .zero       (zero),
      .mem_ready  (mem_ready),
      .mem_req    (mem_req),
      .mem_we     (mem_we),
      .addr_sel   (addr_sel),
      .ir_we      (ir_we),
      .pc_we      (pc_we),
      .pc_src     (pc_src),
      .alu_src_a  (alu_src_a),
      .alu_src_b  (alu_src_b),
      .alu_op     (alu_op),
      .reg_we     (reg_we),
      .wb_sel     (wb_sel),
      .retire     (retire),
      .trap       (trap),
      .trap_cause (trap_cause)
   );

   assign obs = {mem_req, mem_we, addr_sel, ir_we, pc_we, pc_src, alu_src_a,
                 alu_src_b, alu_op, reg_we, wb_sel, retire, trap, trap_cause};

   initial begin
      #1_000_000;
      $display("FAIL watchdog: observed no end of test, required end before 1ms");
      $fatal(1, "watchdog");
   end

   // ---------------- expected control words ----------------
   function automatic ctl_t exp_fetch(input logic rdy);
      ctl_t e = '0;
      e.mem_req = 1'b1; e.alu_src_b = 2'b01; e.ir_we = rdy; e.pc_we = rdy;
      return e;
   endfunction

   function automatic ctl_t exp_decode();
      ctl_t e = '0;
      e.alu_src_a = 1'b1; e.alu_src_b = 2'b10;
      return e;
   endfunction

   function automatic ctl_t exp_exec(input logic [1:0] srcb);
      ctl_t e = '0;
      e.alu_src_b = srcb; e.alu_op = 2'b10;
      return e;
   endfunction

   function automatic ctl_t exp_mem_addr();
      ctl_t e = '0;
      e.alu_src_b = 2'b10;
      return e;
   endfunction

   function automatic ctl_t exp_mem_rd();
      ctl_t e = '0;
      e.mem_req = 1'b1; e.addr_sel = 1'b1;
      return e;
   endfunction

   function automatic ctl_t exp_mem_wr(input logic rdy);
      ctl_t e = '0;
      e.mem_req = 1'b1; e.mem_we = 1'b1; e.addr_sel = 1'b1; e.retire = rdy;
      return e;
   endfunction

   function automatic ctl_t exp_wb(input logic from_mem);
      ctl_t e = '0;
      e.reg_we = 1'b1; e.wb_sel = from_mem; e.retire = 1'b1;
      return e;
   endfunction

   function automatic ctl_t exp_branch(input logic zf);
      ctl_t e = '0;
      e.alu_op = 2'b01; e.pc_src = 1'b1; e.pc_we = zf; e.retire = 1'b1;
      return e;
   endfunction

   function automatic ctl_t exp_trap(input logic [1:0] cause);
      ctl_t e = '0;
      e.trap = 1'b1; e.trap_cause = cause;
      return e;
   endfunction

   function automatic kind_e classify(input logic [31:0] ir);
      case (ir[6:0])
         7'b0110011: return K_R;
         7'b0010011: return K_I;
         7'b0000011: return (ir[14:12] == 3'b010) ? K_LW : K_ILL;
         7'b0100011: return (ir[14:12] == 3'b010) ? K_SW : K_ILL;
         7'b1100011: return (ir[14:12] == 3'b000) ? K_BR : K_ILL;
         default:    return K_ILL;
      endcase
   endfunction

   function automatic logic rb();
      return logic'($urandom_range(0, 1));
   endfunction

   // ---------------- checking / stepping ----------------
   task automatic check(input string tag, input ctl_t e);
      n_checks++;
      assert (obs === e) else begin
         n_fail++;
         $error("FAIL %s: observed %h required %h", tag, obs, e);
      end
   endtask

   // Entered and left at posedge+1; outputs sampled on the falling edge.
   task automatic step(input logic rdy, input logic zf, input ctl_t e, input string tag);
      mem_ready = rdy;
      zero      = zf;
      @(negedge clk);
      check(tag, e);
      @(posedge clk);
      #1;
   endtask

   task automatic trap_hold(input logic [1:0] cause, input int unsigned n);
      for (int unsigned i = 0; i < n; i++)
         step(rb(), rb(), exp_trap(cause), "trap_hold");
   endtask

   // n cycles with mem_ready low; more than TO of them ends in a timeout trap.
   task automatic mem_wait(input int unsigned n, input ctl_t e, input string tag, output bit trapped);
      trapped = 1'b0;
      for (int unsigned i = 0; i < n; i++) begin
         step(1'b0, rb(), e, tag);
         if (i == TO) begin
            trap_hold(2'b10, 3);
            trapped = 1'b1;
            break;
         end
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      #1;
      check("reset", '0);
      @(posedge clk);
      #1;
      check("reset_hold", '0);
      rst = 1'b0;
   endtask

   task automatic run_instr(input logic [31:0] ir, input logic zf, input int unsigned fw,
                            input int unsigned dw, output bit trapped);
      kind_e k;
      mem_wait(fw, exp_fetch(1'b0), "fetch_wait", trapped);
      if (trapped) return;
      step(1'b1, rb(), exp_fetch(1'b1), "fetch_done");
      opcode = ir[6:0];
      funct3 = ir[14:12];
      k = classify(ir);
      step(rb(), rb(), exp_decode(), "decode");
      case (k)
         K_R, K_I: begin
            step(rb(), rb(), exp_exec((k == K_R) ? 2'b00 : 2'b10), "exec");
            step(rb(), rb(), exp_wb(1'b0), "wb_alu");
         end
         K_LW: begin
            step(rb(), rb(), exp_mem_addr(), "mem_addr");
            mem_wait(dw, exp_mem_rd(), "mem_rd_wait", trapped);
            if (!trapped) begin
               step(1'b1, rb(), exp_mem_rd(), "mem_rd_done");
               step(rb(), rb(), exp_wb(1'b1), "wb_mem");
            end
         end
         K_SW: begin
            step(rb(), rb(), exp_mem_addr(), "mem_addr");
            mem_wait(dw, exp_mem_wr(1'b0), "mem_wr_wait", trapped);
            if (!trapped) step(1'b1, rb(), exp_mem_wr(1'b1), "mem_wr_done");
         end
         K_BR: step(rb(), zf, exp_branch(zf), "branch");
         default: begin
            trap_hold(2'b01, 20);
            trapped = 1'b1;
         end
      endcase
   endtask

   // ---------------- sequence ----------------
   initial begin
      bit          tr;
      logic [31:0] ir;
      int unsigned sel, fw, dw;

      @(posedge clk);
      #1;
      do_reset();

      run_instr(32'h00208033, 1'b0, 0, 0, tr);   // add, no waits
      run_instr(32'h0000A103, 1'b0, 0, 3, tr);   // lw, 3 wait cycles in MEM_RD
      run_instr(32'h00208463, 1'b1, 0, 0, tr);   // beq taken
      run_instr(32'h00208463, 1'b0, 1, 0, tr);   // beq not taken
      run_instr(32'h0020A223, 1'b0, 2, 2, tr);   // sw
      run_instr(32'h00108093, 1'b0, 0, 0, tr);   // addi

      run_instr(32'h0000007F, 1'b0, 0, 0, tr);   // illegal -> trap cause 01
      do_reset();

      run_instr(32'h00208033, 1'b0, TO + 1, 0, tr);  // fetch timeout
      do_reset();
      run_instr(32'h00208033, 1'b0, TO, 0, tr);      // ready on the boundary cycle
      run_instr(32'h0000A103, 1'b0, 0, TO + 1, tr);  // MEM_RD timeout
      do_reset();
      run_instr(32'h0020A223, 1'b0, 0, TO + 1, tr);  // MEM_WR timeout
      do_reset();
      run_instr(32'h0020A223, 1'b0, 0, TO, tr);      // MEM_WR boundary, no trap

      // reset in the middle of a store access
      step(1'b1, rb(), exp_fetch(1'b1), "t6_fetch");
      opcode = 7'b0100011;
      funct3 = 3'b010;
      step(rb(), rb(), exp_decode(), "t6_decode");
      step(rb(), rb(), exp_mem_addr(), "t6_mem_addr");
      mem_ready = 1'b0;
      #2;
      check("t6_mem_wr", exp_mem_wr(1'b0));
      rst = 1'b1;
      #1;
      check("t6_rst_async", '0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b0, rb(), exp_fetch(1'b0), "t6_after_rst");
      run_instr(32'h00208033, 1'b0, 0, 0, tr);

      for (int unsigned n = 0; n < 250; n++) begin
         ir  = $urandom;
         sel = $urandom_range(0, 15);
         if (sel < 3)       ir[6:0] = 7'b0110011;
         else if (sel < 6)  ir[6:0] = 7'b0010011;
         else if (sel < 9)  begin ir[6:0] = 7'b0000011; ir[14:12] = 3'b010; end
         else if (sel < 12) begin ir[6:0] = 7'b0100011; ir[14:12] = 3'b010; end
         else if (sel < 15) begin ir[6:0] = 7'b1100011; ir[14:12] = 3'b000; end
         fw = ($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, TO);
         dw = ($urandom_range(0, 15) == 0) ? TO + 1 : $urandom_range(0, TO);
         run_instr(ir, rb(), fw, dw, tr);
         if (tr) do_reset();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
